// File: rtl/rpsc_pkg.sv
// Shared types and default timing constants for the RPSC card 2 power-supply sequencer.
package rpsc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    G1_RAMP  = 3'd1,
    AN_RAMP  = 3'd2,
    RUN      = 3'd3,
    SHUTDOWN = 3'd4,
    FAULT    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    G1_ALARM   = 3'd1,
    G1_TIMEOUT = 3'd2,
    G1_LOST    = 3'd3,
    AN_ALARM   = 3'd4,
    AN_TIMEOUT = 3'd5,
    AN_LOST    = 3'd6
  } fault_t;

  // Defaults assume the 1.28 us system clock.
  localparam int DEF_TO_WIDTH   = 23;
  localparam int DEF_G1_TIMEOUT = 3906250;
  localparam int DEF_AN_TIMEOUT = 6250000;
  localparam int DEF_OFF_DELAY  = 781250;

endpackage

// File: rtl/rpsc_ps_sequencer_sync2.sv
// Two-flop synchronizer with a configurable reset value for card 2 status pins.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rpsc_ps_sequencer.sv
// G1/anode power-supply on/off sequencer for RPSC card 2 with ramp timeouts,
// anode-first shutdown and a first-fault latch held until acknowledged.
module rpsc_ps_sequencer
  import rpsc_pkg::*;
#(
  parameter int TO_WIDTH   = DEF_TO_WIDTH,
  parameter int G1_TIMEOUT = DEF_G1_TIMEOUT,
  parameter int AN_TIMEOUT = DEF_AN_TIMEOUT,
  parameter int OFF_DELAY  = DEF_OFF_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_on,
  input  logic       cmd_off,
  input  logic       fault_ack,
  input  logic       g1_not_alarm,
  input  logic       g1_not_ok,
  input  logic       an_not_alarm,
  input  logic       an_not_th_ready,
  input  logic       an_ok,
  output logic       g1_ps_act,
  output logic       an_ps_act,
  output logic       hv_on,
  output logic       fault_latched,
  output logic [2:0] fault_code,
  output logic [2:0] state
);

  localparam logic [TO_WIDTH-1:0] G1_LAST  = TO_WIDTH'(G1_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] AN_LAST  = TO_WIDTH'(AN_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] OFF_LAST = TO_WIDTH'(OFF_DELAY - 1);

  logic g1_na_s, g1_nok_s, an_na_s, an_ntr_s, an_ok_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync_g1_na  (.clk(clk), .reset(reset), .d(g1_not_alarm),    .q(g1_na_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_g1_nok (.clk(clk), .reset(reset), .d(g1_not_ok),       .q(g1_nok_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_an_na  (.clk(clk), .reset(reset), .d(an_not_alarm),    .q(an_na_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_an_ntr (.clk(clk), .reset(reset), .d(an_not_th_ready), .q(an_ntr_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_an_ok  (.clk(clk), .reset(reset), .d(an_ok),           .q(an_ok_s));

  state_t              cur_state, next_state;
  fault_t              cur_code, next_code, detected;
  logic [TO_WIDTH-1:0] cnt;

  always_comb begin
    detected   = rpsc_pkg::NONE;
    next_state = cur_state;
    next_code  = cur_code;

    // Checks are ordered by code so the lowest simultaneous fault wins.
    case (cur_state)
      G1_RAMP: begin
        if (!g1_na_s)            detected = rpsc_pkg::G1_ALARM;
        else if (cnt >= G1_LAST) detected = rpsc_pkg::G1_TIMEOUT;
        else if (!an_na_s)       detected = rpsc_pkg::AN_ALARM;
      end
      AN_RAMP: begin
        if (!g1_na_s)            detected = rpsc_pkg::G1_ALARM;
        else if (g1_nok_s)       detected = rpsc_pkg::G1_LOST;
        else if (!an_na_s)       detected = rpsc_pkg::AN_ALARM;
        else if (cnt >= AN_LAST) detected = rpsc_pkg::AN_TIMEOUT;
      end
      RUN: begin
        if (!g1_na_s)            detected = rpsc_pkg::G1_ALARM;
        else if (g1_nok_s)       detected = rpsc_pkg::G1_LOST;
        else if (!an_na_s)       detected = rpsc_pkg::AN_ALARM;
        else if (!an_ok_s)       detected = rpsc_pkg::AN_LOST;
      end
      SHUTDOWN: begin
        if (!g1_na_s)            detected = rpsc_pkg::G1_ALARM;
        else if (!an_na_s)       detected = rpsc_pkg::AN_ALARM;
      end
      default: detected = rpsc_pkg::NONE;
    endcase

    case (cur_state)
      IDLE:     if (cmd_on && !cmd_off && g1_na_s && an_na_s) next_state = G1_RAMP;
      G1_RAMP: begin
        if (cmd_off)                    next_state = SHUTDOWN;
        else if (!g1_nok_s && !an_ntr_s) next_state = AN_RAMP;
      end
      AN_RAMP: begin
        if (cmd_off)      next_state = SHUTDOWN;
        else if (an_ok_s) next_state = RUN;
      end
      RUN:      if (cmd_off) next_state = SHUTDOWN;
      SHUTDOWN: if (cnt >= OFF_LAST) next_state = IDLE;
      FAULT: begin
        if (fault_ack && g1_na_s && an_na_s) begin
          next_state = IDLE;
          next_code  = rpsc_pkg::NONE;
        end
      end
      default: begin
        next_state = IDLE;
        next_code  = rpsc_pkg::NONE;
      end
    endcase

    if (detected != rpsc_pkg::NONE) begin
      next_state = FAULT;
      next_code  = detected;
    end
  end

  // Outputs are decoded from next_state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= IDLE;
      cur_code      <= rpsc_pkg::NONE;
      cnt           <= '0;
      g1_ps_act     <= 1'b0;
      an_ps_act     <= 1'b0;
      hv_on         <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      cur_state <= next_state;
      cur_code  <= next_code;
      if (next_state != cur_state) cnt <= '0;
      else if (!(&cnt))            cnt <= cnt + 1'b1;
      g1_ps_act     <= next_state inside {G1_RAMP, AN_RAMP, RUN, SHUTDOWN};
      an_ps_act     <= next_state inside {AN_RAMP, RUN};
      hv_on         <= (next_state == RUN);
      fault_latched <= (next_state == FAULT);
    end
  end

  assign state      = cur_state;
  assign fault_code = cur_code;

endmodule
